// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch stage: PC, single-outstanding imem requests, instruction FIFO
// Holds at most one memory request in flight and only issues when the FIFO has room for its response.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 10,
  parameter int INST_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     id_ready,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_rvalid,
  input  logic [INST_W-1:0]        imem_rdata,
  output logic                     inst_valid,
  output logic [INST_W-1:0]        inst_out,
  output logic [PC_W-1:0]          pc_out,
  output logic [PC_W-1:0]          pc1_out,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   req_pc_q, req_pc_d;
  logic              outstanding_q, outstanding_d;
  logic              discard_q, discard_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [INST_W-1:0] inst_mem_q [DEPTH];
  logic [PC_W-1:0]   pc_mem_q   [DEPTH];

  logic [CW:0]       credit;
  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;

  // Credits cover both stored entries and the response still in flight.
  always_comb begin
    credit   = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};
    issue    = !rst && !outstanding_q && (credit < (CW+1)'(DEPTH)) && !redirect;
    resp     = imem_rvalid && outstanding_q;
    push     = resp && !discard_q && !redirect;
    pop      = inst_valid && id_ready && !redirect;
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // A response landing with the redirect is simply dropped; otherwise the stale one is marked.
      if (outstanding_q) begin
        if (imem_rvalid) begin
          outstanding_d = 1'b0;
          discard_d     = 1'b0;
        end else begin
          discard_d     = 1'b1;
        end
      end
    end else begin
      if (resp) begin
        outstanding_d = 1'b0;
        discard_d     = 1'b0;
      end
      if (issue) begin
        req_pc_d      = fetch_pc_q;
        outstanding_d = 1'b1;
        fetch_pc_d    = fetch_pc_q + PC_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= '0;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  // Head fields read as zero whenever the queue is empty.
  always_comb begin
    inst_valid = (count_q != '0);
    inst_out   = '0;
    pc_out     = '0;
    pc1_out    = '0;
    if (inst_valid) begin
      inst_out = inst_mem_q[rd_ptr_q];
      pc_out   = pc_mem_q[rd_ptr_q];
      pc1_out  = pc_mem_q[rd_ptr_q] + PC_W'(1);
    end
  end

  assign fifo_count = count_q;

endmodule
